// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the opcode field layout used
// by the optional halt-opcode detection (HALT_DETECT_EN).
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_LOAD,
      S_START,
      S_EXEC,
      S_HALT
   } fetch_state_t;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam logic [2:0] OPC_HALT = 3'b111;

   // True when the instruction word carries the halt opcode.
   function automatic logic is_halt_opcode(input logic [15:0] word);
      return (word[OPC_MSB:OPC_LSB] == OPC_HALT);
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts cycles spent waiting for instruction memory read data.
// done is raised during the MAX_WAIT-th consecutive enabled cycle, so the
// owner can leave on that same clock edge.
module fetch_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] count;

   // Wait-cycle counter: cleared on request, advances while enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !done) begin
         count <= count + 1'b1;
      end
   end

   assign done = en && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads 16-bit words
// from instruction memory and hands each one to the cpu with a load
// pulse followed by a start pulse, then waits for the cpu to finish.
// A branch target written during execution redirects the next fetch.
// Optional feature macro: HALT_DETECT_EN (halt opcode stops fetching).
module instr_fetch_unit #(
   parameter int ADDR_W   = 9,
   parameter int RESET_PC = 0,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       ir_out,
   output logic              ir_load,
   output logic              cpu_s,
   input  logic              cpu_w,
   input  logic              pc_wr,
   input  logic [ADDR_W-1:0] pc_wdata,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fetch_err
);

   import fetch_pkg::*;

   fetch_state_t      state;
   logic              busy_seen;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_pc;
   logic              timer_clr;
   logic              timer_en;
   logic              timer_done;

   assign mem_addr  = pc;
   assign timer_en  = (state == S_WAIT);
   assign timer_clr = (state != S_WAIT) || mem_rvalid;

   fetch_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .clr  (timer_clr),
      .en   (timer_en),
      .done (timer_done)
   );

   // Fetch sequencer with registered strobes; the strobe for a state is
   // set on the edge that enters it so it is high for exactly that cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         pc         <= ADDR_W'(RESET_PC);
         ir_out     <= '0;
         mem_rd     <= 1'b0;
         ir_load    <= 1'b0;
         cpu_s      <= 1'b0;
         halted     <= 1'b0;
         fetch_err  <= 1'b0;
         busy_seen  <= 1'b0;
         pend_valid <= 1'b0;
         pend_pc    <= '0;
      end else begin
         mem_rd  <= 1'b0;
         ir_load <= 1'b0;
         cpu_s   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run && cpu_w) begin
                  state  <= S_REQ;
                  mem_rd <= 1'b1;
               end
            end
            S_REQ: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  ir_out <= mem_rdata;
`ifdef HALT_DETECT_EN
                  if (is_halt_opcode(mem_rdata)) begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end else begin
                     pc      <= pc + 1'b1;
                     state   <= S_LOAD;
                     ir_load <= 1'b1;
                  end
`else
                  pc      <= pc + 1'b1;
                  state   <= S_LOAD;
                  ir_load <= 1'b1;
`endif
               end else if (timer_done) begin
                  fetch_err <= 1'b1;
                  halted    <= 1'b1;
                  state     <= S_HALT;
               end
            end
            S_LOAD: begin
               state <= S_START;
               cpu_s <= 1'b1;
            end
            S_START: begin
               state      <= S_EXEC;
               busy_seen  <= 1'b0;
               pend_valid <= 1'b0;
            end
            S_EXEC: begin
               if (!cpu_w) begin
                  busy_seen <= 1'b1;
               end
               if (pc_wr) begin
                  pend_valid <= 1'b1;
                  pend_pc    <= pc_wdata;
               end
               if (busy_seen && cpu_w) begin
                  if (pc_wr) begin
                     pc <= pc_wdata;
                  end else if (pend_valid) begin
                     pc <= pend_pc;
                  end
                  if (run) begin
                     state  <= S_REQ;
                     mem_rd <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_HALT: begin
               state  <= S_HALT;
               halted <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
